// File: rtl/rv32i_alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU and its debug halt controller.
package rv32i_alu_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned DBG_AW_DEF = 8;
  localparam int unsigned CTRL_W     = 4;
  localparam int unsigned DBG_DW     = 32;

  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [DBG_AW_DEF-1:0] DBG_ADDR_CTRL    = 8'h00;
  localparam logic [DBG_AW_DEF-1:0] DBG_ADDR_STATUS  = 8'h04;
  localparam logic [DBG_AW_DEF-1:0] DBG_ADDR_SCRATCH = 8'h08;
  localparam logic [DBG_AW_DEF-1:0] DBG_ADDR_ALU_CAP = 8'h0C;
  localparam logic [DBG_AW_DEF-1:0] DBG_ADDR_STEPCNT = 8'h10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } halt_state_t;

endpackage

// File: rtl/rv32i_alu_datapath.sv
// Combinational ALUOp/funct3/funct7 decode and 32-bit RV32I ALU with zero flag.
module rv32i_alu_datapath
  import rv32i_alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt;
  logic               alt;
  logic               unused_funct7;

  assign shamt         = op_b[SHAMT_W-1:0];
  assign alt           = funct7[5];
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // I-type never treats funct7 as SUB selector (it is immediate bits), but SRAI still does
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = (alu_op == ALUOP_RTYPE && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_ADD:  result = op_a + op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SLL:  result = op_a << shamt;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLT:  result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SRA:  result = XLEN'($signed(op_a) >>> shamt);
      ALU_SLTU: result = XLEN'(op_a < op_b);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rv32i_alu_debug_unit.sv
// Execute-stage ALU plus JTAG-driven debug register bank and run/halt/step controller.
// Optional build macro ALU_RESULT_CAPTURE_EN adds the ALU_CAP result capture register.
module rv32i_alu_debug_unit
  import rv32i_alu_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned DBG_AW = DBG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  input  logic              dbg_enable,
  input  logic              dbg_rd_wr,
  input  logic [DBG_AW-1:0] dbg_addr,
  input  logic [DBG_DW-1:0] dbg_wdata,
  output logic [DBG_DW-1:0] dbg_rdata,
  input  logic              dbg_step,
  input  logic              dbg_run,
  output logic              halt
);

  rv32i_alu_datapath #(.XLEN(XLEN)) u_datapath (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7   (funct7),
    .op_a     (op_a),
    .op_b     (op_b),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero)
  );

  halt_state_t       state;
  halt_state_t       next_state;
  logic              run_q;
  logic              step_q;
  logic              run_edge;
  logic              step_edge;
  logic              wr_en;
  logic              rd_en;
  logic              halt_wr;
  logic              stepcnt_wr;
  logic [DBG_DW-1:0] scratch;
  logic [DBG_DW-1:0] stepcnt;
  logic [DBG_DW-1:0] alu_cap;
  logic [DBG_DW-1:0] rd_mux;

  assign run_edge   = dbg_run  & ~run_q;
  assign step_edge  = dbg_step & ~step_q;
  assign wr_en      = dbg_enable &  dbg_rd_wr;
  assign rd_en      = dbg_enable & ~dbg_rd_wr;
  assign halt_wr    = wr_en && (dbg_addr == DBG_AW'(DBG_ADDR_CTRL)) && dbg_wdata[0];
  assign stepcnt_wr = wr_en && (dbg_addr == DBG_AW'(DBG_ADDR_STEPCNT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      run_q  <= dbg_run;
      step_q <= dbg_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      halt  <= 1'b0;
    end else begin
      state <= next_state;
      halt  <= (next_state == ST_HALTED);
    end
  end

  // Run edge always wins; a run edge during the step cycle resumes instead of re-halting
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (!run_edge && halt_wr) next_state = ST_HALTED;
      end
      ST_HALTED: begin
        if (run_edge)                   next_state = ST_RUN;
        else if (!halt_wr && step_edge) next_state = ST_STEP;
      end
      ST_STEP: begin
        next_state = run_edge ? ST_RUN : ST_HALTED;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch <= '0;
      stepcnt <= '0;
    end else begin
      if (wr_en && (dbg_addr == DBG_AW'(DBG_ADDR_SCRATCH))) scratch <= dbg_wdata;
      if (stepcnt_wr)              stepcnt <= '0;
      else if (state == ST_STEP)   stepcnt <= stepcnt + DBG_DW'(1);
    end
  end

`ifdef ALU_RESULT_CAPTURE_EN
  // Freezes on halt so the debugger sees the last result the core produced
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      alu_cap <= '0;
    else if (!halt) alu_cap <= DBG_DW'(result);
  end
`else
  assign alu_cap = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (dbg_addr)
      DBG_AW'(DBG_ADDR_CTRL):    rd_mux = {31'b0, halt};
      DBG_AW'(DBG_ADDR_STATUS):  rd_mux = {30'b0, (state == ST_STEP), halt};
      DBG_AW'(DBG_ADDR_SCRATCH): rd_mux = scratch;
      DBG_AW'(DBG_ADDR_ALU_CAP): rd_mux = alu_cap;
      DBG_AW'(DBG_ADDR_STEPCNT): rd_mux = stepcnt;
      default:                   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      dbg_rdata <= '0;
    else if (rd_en) dbg_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_rv32i_alu_debug_unit.sv
// Self-checking bench: behavioural ALU/debug model compared every cycle, directed plus random stimulus.
module tb_rv32i_alu_debug_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a, op_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        dbg_enable, dbg_rd_wr;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_step, dbg_run, halt;

  int checks = 0;
  int errors = 0;

  // model: 0 running, 1 halted, 2 single-step cycle
  int          m_state;
  logic [31:0] m_scratch, m_stepcnt, m_cap, m_rdata;
  logic        m_run_q, m_step_q;

  always #5 clk = ~clk;

  rv32i_alu_debug_unit dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
    .op_a(op_a), .op_b(op_b), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
    .dbg_enable(dbg_enable), .dbg_rd_wr(dbg_rd_wr), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_step(dbg_step),
    .dbg_run(dbg_run), .halt(halt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (f3)
      3'd0:    return (op == 2'b10 && f7[5]) ? 4'b0110 : 4'b0010;
      3'd1:    return 4'b0100;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b1001;
      3'd4:    return 4'b0011;
      3'd5:    return f7[5] ? 4'b1000 : 4'b0101;
      3'd6:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] ones;
    int unsigned sh;
    logic        lt_signed;
    ones = 32'hFFFF_FFFF;
    sh   = int'(b & 32'd31);
    lt_signed = (a[31] != b[31]) ? a[31] : (a < b);
    case (code)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0110: return a - b;
      4'b0111: return lt_signed ? 32'd1 : 32'd0;
      4'b1000: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      4'b1001: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] addr);
    case (addr)
      8'h00: return {31'b0, (m_state == 1)};
      8'h04: return {30'b0, (m_state == 2), (m_state == 1)};
      8'h08: return m_scratch;
`ifdef ALU_RESULT_CAPTURE_EN
      8'h0C: return m_cap;
`endif
      8'h10: return m_stepcnt;
      default: return 32'd0;
    endcase
  endfunction

  // Inputs are already applied; check comb outputs, clock once, check registered outputs.
  task automatic cycle();
    logic [3:0]  ec;
    logic [31:0] er, n_rdata, n_scratch, n_stepcnt, n_cap;
    logic        run_e, step_e, wr, rd, halt_wr;
    int          n_state;
    #1;
    ec = ref_ctrl(alu_op, funct3, funct7);
    er = ref_result(ec, op_a, op_b);
    chk("alu_ctrl", 32'(alu_ctrl), 32'(ec));
    chk("result", result, er);
    chk("zero", 32'(zero), 32'(er == 32'd0));

    run_e   = dbg_run && !m_run_q;
    step_e  = dbg_step && !m_step_q;
    wr      = dbg_enable && dbg_rd_wr;
    rd      = dbg_enable && !dbg_rd_wr;
    halt_wr = wr && dbg_addr == 8'h00 && dbg_wdata[0];
    n_rdata   = rd ? m_read(dbg_addr) : m_rdata;
    n_scratch = (wr && dbg_addr == 8'h08) ? dbg_wdata : m_scratch;
    n_stepcnt = (wr && dbg_addr == 8'h10) ? 32'd0 :
                (m_state == 2) ? m_stepcnt + 32'd1 : m_stepcnt;
    n_cap     = (m_state != 1) ? er : m_cap;
    if (run_e)                         n_state = 0;
    else if (halt_wr)                  n_state = 1;
    else if (m_state == 1 && step_e)   n_state = 2;
    else if (m_state == 2)             n_state = 1;
    else                               n_state = m_state;

    @(posedge clk);
    #1;
    m_state = n_state; m_rdata = n_rdata; m_scratch = n_scratch;
    m_stepcnt = n_stepcnt; m_cap = n_cap;
    m_run_q = dbg_run; m_step_q = dbg_step;
    chk("halt", 32'(halt), 32'(m_state == 1));
    chk("dbg_rdata", dbg_rdata, m_rdata);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_state = 0; m_scratch = 0; m_stepcnt = 0; m_cap = 0; m_rdata = 0;
    m_run_q = 1'b0; m_step_q = 1'b0;
    chk("reset_halt", 32'(halt), 32'd0);
    chk("reset_rdata", dbg_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_alu(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
  endtask

  task automatic dbg(input logic en, input logic rw, input logic [7:0] addr,
                     input logic [31:0] wd);
    dbg_enable = en; dbg_rd_wr = rw; dbg_addr = addr; dbg_wdata = wd;
  endtask

  initial begin
    reset = 1'b1;
    set_alu(2'b00, 3'd0, 7'd0, 32'd0, 32'd0);
    dbg(1'b0, 1'b0, 8'h00, 32'd0);
    dbg_step = 1'b0; dbg_run = 1'b0;
    do_reset();

    set_alu(2'b10, 3'd0, 7'h20, 32'd5, 32'd7);
    cycle();
    chk("tp_sub_ctrl", 32'(alu_ctrl), 32'h6);
    chk("tp_sub_result", result, 32'hFFFF_FFFE);
    chk("tp_sub_zero", 32'(zero), 32'd0);
    set_alu(2'b11, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    cycle();
    chk("tp_srai_ctrl", 32'(alu_ctrl), 32'h8);
    chk("tp_srai_result", result, 32'hF800_0000);
    set_alu(2'b11, 3'd5, 7'h00, 32'h8000_0000, 32'd4);
    cycle();
    chk("tp_srli_result", result, 32'h0800_0000);
    set_alu(2'b10, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1);
    cycle();
    chk("tp_slt", result, 32'd1);
    set_alu(2'b10, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1);
    cycle();
    chk("tp_sltu", result, 32'd0);
    set_alu(2'b11, 3'd0, 7'h20, 32'd5, 32'd7);
    cycle();
    chk("tp_addi_ignores_f7", result, 32'd12);
    set_alu(2'b01, 3'd0, 7'h00, 32'd9, 32'd9);
    cycle();
    chk("tp_beq_zero", 32'(zero), 32'd1);

    // halt, single step, resume
    dbg(1'b1, 1'b1, 8'h00, 32'd1); cycle();
    chk("tp_halt_set", 32'(halt), 32'd1);
    dbg(1'b0, 1'b0, 8'h00, 32'd0); dbg_step = 1'b1; cycle();
    chk("tp_step_low", 32'(halt), 32'd0);
    cycle();
    chk("tp_step_back", 32'(halt), 32'd1);
    dbg_step = 1'b0; dbg(1'b1, 1'b0, 8'h10, 32'd0); cycle();
    chk("tp_stepcnt_one", dbg_rdata, 32'd1);
    dbg(1'b0, 1'b0, 8'h00, 32'd0); dbg_run = 1'b1; cycle();
    chk("tp_run_resume", 32'(halt), 32'd0);
    dbg_run = 1'b0; cycle();

    // run edge beats a coincident halt write
    dbg(1'b1, 1'b1, 8'h00, 32'd1); dbg_run = 1'b1; cycle();
    chk("tp_run_beats_halt", 32'(halt), 32'd0);
    dbg_run = 1'b0; dbg(1'b1, 1'b1, 8'h10, 32'hFFFF_FFFF); cycle();
    dbg(1'b0, 1'b0, 8'h00, 32'd0); dbg_step = 1'b1; cycle();
    dbg_step = 1'b0; dbg(1'b1, 1'b0, 8'h10, 32'd0); cycle();
    chk("tp_step_ignored_running", dbg_rdata, 32'd0);

    dbg(1'b1, 1'b1, 8'h08, 32'hDEAD_BEEF); cycle();
    dbg(1'b1, 1'b0, 8'h08, 32'd0); cycle();
    chk("tp_scratch", dbg_rdata, 32'hDEAD_BEEF);

    // reset in the middle of a step
    dbg(1'b1, 1'b1, 8'h00, 32'd1); cycle();
    dbg(1'b0, 1'b0, 8'h00, 32'd0); dbg_step = 1'b1; cycle();
    chk("tp_in_step", 32'(halt), 32'd0);
    do_reset();
    chk("tp_midstep_halt", 32'(halt), 32'd0);
    dbg_step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dbg(1'b1, 1'b0, 8'(i * 4), 32'd0);
      cycle();
      chk("tp_reg_after_reset", dbg_rdata, 32'd0);
    end

    for (int n = 0; n < 3000; n++) begin
      alu_op = 2'($urandom_range(0, 3));
      funct3 = 3'($urandom);
      funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
      op_a   = $urandom;
      op_b   = ($urandom_range(0, 7) == 0) ? op_a : $urandom;
      dbg_enable = 1'($urandom_range(0, 1));
      dbg_rd_wr  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: dbg_addr = 8'h00;
        1: dbg_addr = 8'h04;
        2: dbg_addr = 8'h08;
        3: dbg_addr = 8'h0C;
        4: dbg_addr = 8'h10;
        5: dbg_addr = 8'h14;
        default: dbg_addr = 8'($urandom);
      endcase
      dbg_wdata = $urandom;
      if ($urandom_range(0, 7) == 0) dbg_run = ~dbg_run;
      if ($urandom_range(0, 3) == 0) dbg_step = ~dbg_step;
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
